// File: rtl/conv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// conv_pkg : shared sizes, state encoding and helpers for the conv path
// Rev 1.0
// ----------------------------------------------------------------------
package conv_pkg;

    localparam int N_DEF   = 3;
    localparam int M_DEF   = 2;
    localparam int DW_DEF  = 32;
    localparam int TMO_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KRST   = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } conv_state_e;

    function automatic int words(input int n, input int m);
        return m * m + n * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_word_buf.sv
`default_nettype none
// ----------------------------------------------------------------------
// conv_word_buf : kernel+image word store, sync write / async read
// Rev 1.0
// ----------------------------------------------------------------------
module conv_word_buf
    import conv_pkg::*;
#(
    parameter int WORDS = words(N_DEF, M_DEF),
    parameter int DW    = DW_DEF,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // Contents deliberately survive reset so a loaded frame can be re-run.
    logic [DW-1:0] mem_q [WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < WORDS) ? mem_q[rd_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/conv_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------
// conv_feeder : resets the conv core, streams kernel then image, waits
//               for end_conv with a timeout
// Rev 1.0
// ----------------------------------------------------------------------
module conv_feeder
    import conv_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int M     = M_DEF,
    parameter  int DW    = DW_DEF,
    parameter  int TMO   = TMO_DEF,
    localparam int WORDS = words(N, M),
    localparam int AW    = $clog2(WORDS),
    localparam int TW    = $clog2(TMO + 1)
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          end_conv,
    output logic          conv_rst,
    output logic [DW-1:0] a_out,
    output logic          a_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    conv_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          conv_rst_q, conv_rst_d;
    logic [DW-1:0] a_out_q, a_out_d;
    logic          a_valid_q, a_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tmo_hit;
    logic          buf_we;
    logic [DW-1:0] buf_rd_data;

    assign buf_we = wr_en && !busy_q && (int'(wr_addr) < WORDS);

    // Read port follows idx_d so the registered a_out lines up with idx_q.
    conv_word_buf #(
        .WORDS (WORDS),
        .DW    (DW),
        .AW    (AW)
    ) u_buf (
        .clock   (clock),
        .we      (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_d),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tmo_cnt_q  <= '0;
            conv_rst_q <= 1'b0;
            a_out_q    <= '0;
            a_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            conv_rst_q <= conv_rst_d;
            a_out_q    <= a_out_d;
            a_valid_q  <= a_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_KRST;
                end
            end
            ST_KRST: begin
                idx_d   = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (idx_q == AW'(WORDS - 1)) begin
                    state_d   = ST_WAIT;
                    tmo_cnt_d = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_WAIT: begin
                // end_conv takes priority over a timeout landing in the same cycle.
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (end_conv) begin
                    state_d = ST_DONE;
                end else if (tmo_cnt_d == TW'(TMO)) begin
                    tmo_hit = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        conv_rst_d = (state_d == ST_KRST);
        a_valid_d  = (state_d == ST_STREAM);
        a_out_d    = a_valid_d ? buf_rd_data : '0;
        busy_d     = (state_d == ST_KRST) || (state_d == ST_STREAM) || (state_d == ST_WAIT);
        done_d     = (state_d == ST_DONE);
        err_d      = err_q;
        if ((state_q == ST_IDLE) && start) begin
            err_d = 1'b0;
        end else if (tmo_hit) begin
            err_d = 1'b1;
        end
    end

    assign conv_rst = conv_rst_q;
    assign a_out    = a_out_q;
    assign a_valid  = a_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire
